// File: rtl/vga_pkg.sv
// Timing constants, colour type and 3-3-2 colour expansion for the VGA scan-out path.
// Shared by vga_timing and vga_scanout.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE  = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 200;
  localparam int V_OFFSET  = 40;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t BORDER_COLOR = 12'h000;

  function automatic rgb12_t expand_rgb332(input logic [7:0] p);
    rgb12_t c;
    c.r = {p[7:5], p[7]};
    c.g = {p[4:2], p[4]};
    c.b = {p[1:0], p[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 counters, visibility/window/sync flags and pixel-doubled framebuffer address.
// Flags are combinational from the counters; frame_start is registered; no backpressure.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [8:0] fb_x,
  output logic [7:0] fb_y,
  output logic       visible,
  output logic       window,
  output logic       hs_n,
  output logic       vs_n,
  output logic       frame_start,
  output logic       vblank
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WIN_LO   = 10'(V_OFFSET);
  localparam logic [9:0] WIN_HI   = 10'(V_OFFSET + 2 * FB_HEIGHT);

  logic [9:0] h;
  logic [9:0] v;
  logic       h_last;
  logic       v_last;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  // Both counters are written every cycle so they always hold their own next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      h           <= h_last ? '0 : h + 10'd1;
      v           <= h_last ? (v_last ? '0 : v + 10'd1) : v;
      frame_start <= h_last && v_last;
    end
  end

  assign visible = (h < H_VIS) && (v < V_VIS);
  assign window  = visible && (v >= WIN_LO) && (v < WIN_HI);
  assign hs_n    = !((h >= HS_START) && (h < HS_END));
  assign vs_n    = !((v >= VS_START) && (v < VS_END));
  assign vblank  = (v >= V_VIS);

  // Each framebuffer pixel covers a 2x2 block of screen pixels.
  assign fb_x = window ? h[9:1] : '0;
  assign fb_y = window ? 8'((v - WIN_LO) >> 1) : '0;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: timing, framebuffer read, 8-bit to RGB444 (palette when VGA_PALETTE_EN), letterbox border.
// Latency 2 cycles from counters to colour/sync pins; free-running, no backpressure.
module vga_scanout
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [8:0] read_x,
  output logic [7:0] read_y,
  input  logic [7:0] pixel_data,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_start,
  output logic       vblank
`ifdef VGA_PALETTE_EN
  ,
  input  logic       pal_we,
  input  logic [7:0] pal_addr,
  input  logic [11:0] pal_data
`endif
);

  logic [8:0] fb_x;
  logic [7:0] fb_y;
  logic       visible;
  logic       window;
  logic       hs_n;
  logic       vs_n;

  vga_timing u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .visible     (visible),
    .window      (window),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  logic s1_visible;
  logic s1_window;
  logic s1_hs_n;
  logic s1_vs_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_x     <= '0;
      read_y     <= '0;
      s1_visible <= 1'b0;
      s1_window  <= 1'b0;
      s1_hs_n    <= 1'b1;
      s1_vs_n    <= 1'b1;
    end else begin
      read_x     <= fb_x;
      read_y     <= fb_y;
      s1_visible <= visible;
      s1_window  <= window;
      s1_hs_n    <= hs_n;
      s1_vs_n    <= vs_n;
    end
  end

  rgb12_t px_color;

`ifdef VGA_PALETTE_EN
  rgb12_t palette [256];

  // Reset loads the fixed 3-3-2 ramp so an unprogrammed palette looks like the plain build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) palette[i] <= expand_rgb332(8'(i));
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  assign px_color = palette[pixel_data];
`else
  assign px_color = expand_rgb332(pixel_data);
`endif

  rgb12_t next_color;
  rgb12_t color;

  always_comb begin
    next_color = '0;
    if (s1_window)       next_color = px_color;
    else if (s1_visible) next_color = BORDER_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      color  <= next_color;
      vga_hs <= s1_hs_n;
      vga_vs <= s1_vs_n;
    end
  end

  assign vga_r = color.r;
  assign vga_g = color.g;
  assign vga_b = color.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: directed counter positions, expected pin values queued by cycle.
// Positions far into the frame are reached by depositing the timing counters.
module tb_vga_scanout;

  logic       clk;
  logic       rst_n;
  logic [8:0] read_x;
  logic [7:0] read_y;
  logic [7:0] pixel_data;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       frame_start;
  logic       vblank;
`ifdef VGA_PALETTE_EN
  logic       pal_we;
  logic [7:0] pal_addr;
  logic [11:0] pal_data;
`endif

  vga_scanout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_x      (read_x),
    .read_y      (read_y),
    .pixel_data  (pixel_data),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start),
    .vblank      (vblank)
`ifdef VGA_PALETTE_EN
    ,
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer model: two marked corners, everything else 8'h49 (RGB 4,4,5).
  always_comb begin
    pixel_data = 8'h49;
    if (read_x == 9'd0 && read_y == 8'd0)         pixel_data = 8'hE3;
    else if (read_x == 9'd319 && read_y == 8'd199) pixel_data = 8'h1C;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [16:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_rd(input int due, input string nm, input int x, input int y);
    item_t it;
    it.due = due; it.kind = 0; it.exp = {9'(x), 8'(y)}; it.name = nm;
    q.push_back(it);
  endtask

  task automatic expect_px(input int due, input string nm, input logic [11:0] c,
                           input logic hs, input logic vs);
    item_t it;
    it.due = due; it.kind = 1; it.exp = 17'({c, hs, vs}); it.name = nm;
    q.push_back(it);
  endtask

  task automatic expect_fl(input int due, input string nm, input logic fs, input logic vb);
    item_t it;
    it.due = due; it.kind = 2; it.exp = 17'({fs, vb}); it.name = nm;
    q.push_back(it);
  endtask

  item_t       mon_it;
  logic [16:0] mon_act;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_it = q.pop_front();
      case (mon_it.kind)
        0:       mon_act = {read_x, read_y};
        1:       mon_act = 17'({vga_r, vga_g, vga_b, vga_hs, vga_vs});
        default: mon_act = 17'({frame_start, vblank});
      endcase
      n_cmp++;
      if (mon_it.due != cyc) begin
        n_bad++;
        $display("FAIL %s: compared at cycle %0d, required cycle %0d", mon_it.name, cyc, mon_it.due);
      end else if (mon_act !== mon_it.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, want %h (cycle %0d)", mon_it.name, mon_act, mon_it.exp, cyc);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain_timeout: %0d expectations pending, want 0", q.size());
      $fatal(1);
    end
  endtask

  logic [9:0] jh;
  logic [9:0] jv;

  // Leaves the counters at (hh,vv) at the returning negedge; hh must be at least 1.
  task automatic jump(input int hh, input int vv);
    @(negedge clk);
    jh = 10'(hh - 1);
    jv = 10'(vv);
    force dut.u_timing.h = jh;
    force dut.u_timing.v = jv;
    @(negedge clk);
    jh = 10'(hh);
    force dut.u_timing.h = jh;
    force dut.u_timing.v = jv;
    release dut.u_timing.h;
    release dut.u_timing.v;
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    jh    = '0;
    jv    = '0;
`ifdef VGA_PALETTE_EN
    pal_we   = 1'b0;
    pal_addr = '0;
    pal_data = '0;
`endif
    repeat (3) @(negedge clk);
    expect_rd(cyc + 1, "rst_read", 0, 0);
    expect_px(cyc + 1, "rst_pins", 12'h000, 1'b1, 1'b1);
    expect_fl(cyc + 1, "rst_flags", 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Counters sit at (0,0) in the release cycle; h = cyc - base on line 0.
    rst_n = 1'b1;
    base  = cyc;
    expect_fl(base + 1,    "flags_after_rst", 1'b0, 1'b0);
    expect_rd(base + 101,  "read_line0", 0, 0);
    expect_px(base + 657,  "hs_h655", 12'h000, 1'b1, 1'b1);
    expect_px(base + 658,  "hs_h656", 12'h000, 1'b0, 1'b1);
    expect_px(base + 753,  "hs_h751", 12'h000, 1'b0, 1'b1);
    expect_px(base + 754,  "hs_h752", 12'h000, 1'b1, 1'b1);
    expect_px(base + 1457, "hs_l1_h655", 12'h000, 1'b1, 1'b1);
    expect_px(base + 1458, "hs_l1_h656", 12'h000, 1'b0, 1'b1);
    drain();

    // Top of the framebuffer window.
    jump(590, 39);
    base = cyc;
    expect_rd(base + 11,   "read_v39", 0, 0);
    expect_px(base + 12,   "border_v39", 12'h000, 1'b1, 1'b1);
    expect_fl(base + 20,   "vblank_v39", 1'b0, 1'b0);
    expect_px(base + 68,   "hs_v39", 12'h000, 1'b0, 1'b1);
    expect_rd(base + 211,  "read_0_40", 0, 0);
    expect_px(base + 212,  "rgb_0_40", 12'hF0F, 1'b1, 1'b1);
    expect_rd(base + 212,  "read_1_40", 0, 0);
    expect_px(base + 213,  "rgb_1_40", 12'hF0F, 1'b1, 1'b1);
    expect_rd(base + 213,  "read_2_40", 1, 0);
    expect_px(base + 214,  "rgb_2_40", 12'h445, 1'b1, 1'b1);
    expect_rd(base + 850,  "read_639_40", 319, 0);
    expect_px(base + 851,  "rgb_639_40", 12'h445, 1'b1, 1'b1);
    expect_rd(base + 1011, "read_0_41", 0, 0);
    expect_px(base + 1012, "rgb_0_41", 12'hF0F, 1'b1, 1'b1);
    expect_rd(base + 1811, "read_0_42", 0, 1);
    expect_px(base + 1812, "rgb_0_42", 12'h445, 1'b1, 1'b1);
    drain();

    // Bottom of the window and the lower border.
    jump(630, 439);
    base = cyc;
    expect_rd(base + 10,  "read_639_439", 319, 199);
    expect_px(base + 11,  "rgb_639_439", 12'h0F0, 1'b1, 1'b1);
    expect_rd(base + 11,  "read_640_439", 0, 0);
    expect_px(base + 12,  "rgb_640_439", 12'h000, 1'b1, 1'b1);
    expect_rd(base + 171, "read_0_440", 0, 0);
    expect_px(base + 172, "border_0_440", 12'h000, 1'b1, 1'b1);
    expect_rd(base + 271, "read_100_440", 0, 0);
    expect_px(base + 272, "border_100_440", 12'h000, 1'b1, 1'b1);
    drain();

    jump(798, 479);
    base = cyc;
    expect_fl(base + 1, "vblank_v479", 1'b0, 1'b0);
    expect_fl(base + 2, "vblank_v480", 1'b0, 1'b1);
    drain();

    // Vertical sync spans lines 490..491 only.
    jump(798, 489);
    base = cyc;
    expect_px(base + 3,    "vs_799_489", 12'h000, 1'b1, 1'b1);
    expect_px(base + 4,    "vs_0_490", 12'h000, 1'b1, 1'b0);
    expect_px(base + 704,  "vs_hs_700_490", 12'h000, 1'b0, 1'b0);
    expect_px(base + 1603, "vs_799_491", 12'h000, 1'b1, 1'b0);
    expect_px(base + 1604, "vs_0_492", 12'h000, 1'b1, 1'b1);
    drain();

    // Both counters wrap together; frame_start marks the (0,0) cycle.
    jump(795, 524);
    base = cyc;
    expect_fl(base + 4, "fs_799_524", 1'b0, 1'b1);
    expect_fl(base + 5, "fs_0_0", 1'b1, 1'b0);
    expect_fl(base + 6, "fs_1_0", 1'b0, 1'b0);
    expect_rd(base + 6, "read_0_0", 0, 0);
    drain();

    // Asynchronous reset in the middle of a visible line.
    jump(290, 100);
    base = cyc;
    expect_rd(base + 10, "read_299_100", 149, 30);
    expect_px(base + 10, "rgb_298_100", 12'h445, 1'b1, 1'b1);
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_rd(cyc, "midrst_read", 0, 0);
    expect_px(cyc, "midrst_pins", 12'h000, 1'b1, 1'b1);
    expect_fl(cyc, "midrst_flags", 1'b0, 1'b0);
    drain();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    expect_px(base + 657, "postrst_h655", 12'h000, 1'b1, 1'b1);
    expect_px(base + 658, "postrst_h656", 12'h000, 1'b0, 1'b1);
    drain();

`ifdef VGA_PALETTE_EN
    @(negedge clk);
    pal_we   = 1'b1;
    pal_addr = 8'hE3;
    pal_data = 12'h123;
    @(negedge clk);
    pal_we   = 1'b0;
    jump(798, 39);
    base = cyc;
    expect_px(base + 4, "pal_0_40", 12'h123, 1'b1, 1'b1);
    expect_px(base + 6, "pal_2_40", 12'h445, 1'b1, 1'b1);
    drain();
    jump(638, 439);
    base = cyc;
    expect_px(base + 3, "pal_639_439", 12'h0F0, 1'b1, 1'b1);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display scan-out stage downstream of the 320x200x8 framebuffer. It generates 640x480@60 VGA timing from the pixel clock and drives the framebuffer read port with pixel-doubled coordinates. It captures the returned 8-bit pixel, converts it to 12-bit RGB, and drives the VGA pins with sync signals aligned to the colour. The 200 framebuffer rows are letterboxed vertically, with a border colour filling the rows above and below.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- FB_WIDTH / FB_HEIGHT, 320 / 200, framebuffer dimensions
- V_OFFSET, 40, first visible line of the framebuffer window
- BORDER_COLOR, 12'h000, RGB444 colour for visible pixels outside the window
- clk  in  1  pixel clock (25.175 MHz); one pixel per cycle
- reset  in  1  asynchronous, active-low reset
- read_x  out  9  framebuffer read column
- read_y  out  8  framebuffer read row
- pixel_data  in  8  framebuffer pixel, combinational from read_x/read_y, RRRGGGBB
- vga_r / vga_g / vga_b  out  4 each  colour outputs
- vga_hs / vga_vs  out  1  syncs, active-low
- frame_start  out  1  one-cycle pulse at start of frame
- vblank  out  1  high while the line counter is ≥ V_ACTIVE
- pal_we / pal_addr[7:0] / pal_data[11:0]  in  palette write port; present only with VGA_PALETTE_EN

## Operation
- Horizontal counter h (10 bits) runs 0..799 and wraps to 0.
- Vertical counter v (10 bits) increments when h wraps, runs 0..524, and wraps to 0.
- Counter-stage flags:
  - visible = h<640 && v<480.
  - window = visible && V_OFFSET≤v<V_OFFSET+2·FB_HEIGHT.
  - hs_n = !(656≤h<752).
  - vs_n = !(490≤v<492).
- Stage 1 (registered):
  - read_x = h[9:1] and read_y = (v−V_OFFSET)[8:1] when window is true; both are 0 otherwise.
  - visible, window, hs_n and vs_n are delayed one cycle alongside.
- Stage 2 (registered):
  - If window: colour = expand(pixel_data).
  - Else if visible: colour = BORDER_COLOR.
  - Else: colour = 0.
  - vga_hs and vga_vs take the stage-1 sync values.
- expand: R = {p[7:5],p[7]}, G = {p[4:2],p[4]}, B = {p[1:0],p[1:0]}.
- frame_start is registered high for exactly the one cycle in which the counters equal (0,0).
- vblank is combinational from v at the counter stage; upstream pixel writers use it to schedule writes.
- The block never writes the framebuffer. Read addresses are always within 0..319 and 0..199.

## Timing
- Reset values (asynchronous):
  - h, v = 0.
  - read_x, read_y = 0.
  - vga_r, vga_g, vga_b = 0.
  - vga_hs, vga_vs = 1.
  - frame_start = 0; all pipeline registers are cleared.
- After reset release, the first clock edge advances h to 1. The frame restarts at (0,0) and there is no partial-frame recovery.
- Latency: a counter value present in cycle t appears on the colour and sync outputs in cycle t+2. Colour and sync stay mutually aligned in all cases.
- Line period is 800 cycles; frame period is 420000 cycles.
- Boundaries:
  - At h=799 with v=524, both counters wrap in the same cycle.
  - At h=639 with v=439, read = (319,199).
  - At v=440 the border resumes.
- Reset asserted mid-line: all outputs go to their reset values immediately, without waiting for a clock edge.

## Configuration
- VGA_PALETTE_EN defined:
  - Adds a 256x12 palette RAM, synchronous write via pal_we/pal_addr/pal_data.
  - Stage 2 replaces expand(pixel_data) with palette[pixel_data], read combinationally, so latency stays 2.
  - Palette initial contents equal expand(i), so the default image matches the undefined case.
  - A write and a read to the same entry in the same cycle returns the old value.
- VGA_PALETTE_EN undefined: the pal_* ports do not exist and fixed 3-3-2 expansion is used.

## Structure
- Package vga_pkg holds:
  - The timing constants.
  - The typedef rgb12_t (packed 4/4/4).
  - The function expand_rgb332.
- Sub-module vga_timing holds the h/v counters, visible/window/sync flags, frame_start and vblank. vga_scanout instantiates it and adds the two pipeline stages and the optional palette.

## Test plan
- Reset, then count clocks between vga_hs falling edges: 800 cycles apart, with vga_hs low for 96 cycles starting 2 cycles after h=656.
- Over a full frame: vga_vs is low exactly on lines 490–491 (1600 cycles), and frame_start pulses once per 420000 cycles.
- Framebuffer model with (0,0)=8'hE3: at counter (0,40), read = (0,0); two cycles later RGB = F,0,F. Counters (1,40) and (0,41) also read (0,0).
- Model pixel (319,199)=8'h1C: at counter (639,439) → RGB = 0,F,0. At v=440, visible pixels show BORDER_COLOR, and read_x/read_y = 0.
- Assert reset at h=300, v=100: outputs go to reset values before the next edge; after release, the next vga_vs low starts 490·800+2 cycles later.
- With VGA_PALETTE_EN defined: write palette[8'hE3]=12'h123, then show (0,0)=8'hE3 → RGB = 1,2,3. An unwritten index 8'h1C still gives 0,F,0.
